fifo_byte_framer: RTL and testbench

Downstream consumer of the 16-bit fifo. Drains words via the fifo's RD/DOUT/EMPTY/VALID interface and frames every PKT_WORDS words into a byte packet: header, count, payload bytes (MSB first), then checksum. Output is an 8-bit valid/ready stream toward the serial TX stage.

---
 rtl/fifo_byte_framer.sv | 138 +++++++++++++
 tb/tb_fifo_byte_framer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_byte_framer.sv
// Drains 16-bit words from an upstream fifo and frames them into byte packets:
// header, word count, payload bytes (high byte first), then an 8-bit payload checksum.
module fifo_byte_framer #(
    parameter int          PKT_WORDS = 4,
    parameter logic [7:0]  HDR_BYTE  = 8'hA5
) (
    input  logic        CLK,
    input  logic        RST,
    output logic        FIFO_RD,
    input  logic [15:0] FIFO_DOUT,
    input  logic        FIFO_EMPTY,
    input  logic        FIFO_VALID,
    output logic [7:0]  TX_DATA,
    output logic        TX_VALID,
    input  logic        TX_READY,
    output logic        BUSY,
    output logic        ERR
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_CNT,
        S_REQ,
        S_WAIT,
        S_BHI,
        S_BLO,
        S_SUM
    } state_t;

    localparam logic [7:0] CNT_BYTE  = 8'(PKT_WORDS);
    localparam logic [7:0] LAST_WORD = 8'(PKT_WORDS - 1);

    state_t      r_state;
    logic [7:0]  r_wordCount;
    logic [7:0]  r_sum;
    logic [7:0]  r_lowByte;

    logic        w_xfer;
    logic [7:0]  w_sumNext;

    assign w_xfer    = TX_VALID && TX_READY;
    assign w_sumNext = r_sum + TX_DATA;
    assign BUSY      = (r_state != S_IDLE);

    // WAIT spans two cycles: the first while the registered RD strobe is seen by
    // the fifo, the second when its VALID response is expected.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state     <= S_IDLE;
            FIFO_RD     <= 1'b0;
            TX_DATA     <= 8'h00;
            TX_VALID    <= 1'b0;
            ERR         <= 1'b0;
            r_wordCount <= 8'h00;
            r_sum       <= 8'h00;
            r_lowByte   <= 8'h00;
        end else begin
            if (FIFO_VALID && (r_state != S_WAIT)) begin
                ERR <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    r_sum       <= 8'h00;
                    r_wordCount <= 8'h00;
                    FIFO_RD     <= 1'b0;
                    TX_VALID    <= 1'b0;
                    if (!FIFO_EMPTY) begin
                        TX_DATA  <= HDR_BYTE;
                        TX_VALID <= 1'b1;
                        r_state  <= S_HDR;
                    end
                end
                S_HDR: begin
                    if (w_xfer) begin
                        TX_DATA <= CNT_BYTE;
                        r_state <= S_CNT;
                    end
                end
                S_CNT: begin
                    if (w_xfer) begin
                        TX_VALID <= 1'b0;
                        r_state  <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (!FIFO_EMPTY) begin
                        FIFO_RD <= 1'b1;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (FIFO_RD) begin
                        FIFO_RD <= 1'b0;
                    end else if (FIFO_VALID) begin
                        r_lowByte <= FIFO_DOUT[7:0];
                        TX_DATA   <= FIFO_DOUT[15:8];
                        TX_VALID  <= 1'b1;
                        r_state   <= S_BHI;
                    end else begin
                        ERR     <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                S_BHI: begin
                    if (w_xfer) begin
                        r_sum   <= w_sumNext;
                        TX_DATA <= r_lowByte;
                        r_state <= S_BLO;
                    end
                end
                S_BLO: begin
                    if (w_xfer) begin
                        r_sum       <= w_sumNext;
                        r_wordCount <= r_wordCount + 8'h01;
                        if (r_wordCount == LAST_WORD) begin
                            TX_DATA <= w_sumNext;
                            r_state <= S_SUM;
                        end else begin
                            TX_VALID <= 1'b0;
                            r_state  <= S_REQ;
                        end
                    end
                end
                S_SUM: begin
                    if (w_xfer) begin
                        TX_VALID <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_byte_framer.sv
// Self-checking bench for fifo_byte_framer: emulates the upstream fifo and
// checks the byte stream against an expected-byte queue built from the words written.
module tb_fifo_byte_framer;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        FIFO_RD;
    logic [15:0] FIFO_DOUT = 16'h0000;
    logic        FIFO_EMPTY = 1'b1;
    logic        FIFO_VALID = 1'b0;
    logic [7:0]  TX_DATA;
    logic        TX_VALID;
    logic        TX_READY = 1'b1;
    logic        BUSY;
    logic        ERR;

    int          checks = 0;
    int          failures = 0;

    logic [15:0] fifoQ[$];
    logic [7:0]  expQ[$];
    int          rdCount = 0;
    int          validCount = 0;
    int          readsIssued = 0;
    int          failAt = -1;
    bit          errPending = 1'b0;
    bit          expErr = 1'b0;
    logic [7:0]  lastByte = 8'h00;
    int          stallLeft = 0;
    logic [7:0]  stallByte = 8'h00;

    fifo_byte_framer #(.PKT_WORDS(4), .HDR_BYTE(8'hA5)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .FIFO_RD    (FIFO_RD),
        .FIFO_DOUT  (FIFO_DOUT),
        .FIFO_EMPTY (FIFO_EMPTY),
        .FIFO_VALID (FIFO_VALID),
        .TX_DATA    (TX_DATA),
        .TX_VALID   (TX_VALID),
        .TX_READY   (TX_READY),
        .BUSY       (BUSY),
        .ERR        (ERR)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] word);
        fifoQ.push_back(word);
        FIFO_EMPTY = 1'b0;
    endtask

    // Expected byte sequence of one 4-word packet, built from the framing rules.
    task automatic expectPacket(input logic [15:0] w0, input logic [15:0] w1,
                                input logic [15:0] w2, input logic [15:0] w3);
        logic [15:0] w [4];
        logic [7:0]  sum;
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
        sum = 8'h00;
        expQ.push_back(8'hA5);
        expQ.push_back(8'h04);
        for (int i = 0; i < 4; i++) begin
            expQ.push_back(w[i][15:8]);
            expQ.push_back(w[i][7:0]);
            sum = sum + w[i][15:8] + w[i][7:0];
        end
        expQ.push_back(sum);
    endtask

    task automatic waitDrain(input string name, input int maxCycles);
        int n = 0;
        while ((expQ.size() != 0 || BUSY) && n < maxCycles) begin
            @(negedge CLK);
            n++;
        end
        checks++;
        if (expQ.size() != 0 || BUSY) begin
            failures++;
            $display("[TB] FAIL %s: timeout, bytes left %0d, busy %0b, required 0 and 0", name, expQ.size(), BUSY);
        end
    endtask

    // Upstream fifo: a read strobe seen at an edge returns data with VALID one cycle later.
    initial begin
        logic rdLatched;
        forever begin
            @(negedge CLK);
            rdLatched = FIFO_RD;
            @(posedge CLK);
            #1;
            if (errPending) begin
                errPending = 1'b0;
                expErr = 1'b1;
                checkOutput("abortErr", 32'(ERR), 32'd1);
                checkOutput("abortBusy", 32'(BUSY), 32'd0);
                checkOutput("abortTxValid", 32'(TX_VALID), 32'd0);
            end
            if (rdLatched && RST && fifoQ.size() != 0) begin
                readsIssued++;
                FIFO_DOUT = fifoQ.pop_front();
                if (readsIssued == failAt) begin
                    FIFO_VALID = 1'b0;
                    errPending = 1'b1;
                end else begin
                    FIFO_VALID = 1'b1;
                end
            end else begin
                FIFO_VALID = 1'b0;
            end
            FIFO_EMPTY = (fifoQ.size() == 0);
        end
    end

    // Sink: holds READY low for a programmed number of cycles while a chosen byte is offered.
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if (stallLeft > 0 && TX_VALID && TX_DATA == stallByte) begin
                TX_READY = 1'b0;
                stallLeft--;
            end else begin
                TX_READY = 1'b1;
            end
        end
    end

    // Per-cycle compare against the expected stream and the fifo/handshake rules.
    initial begin
        logic       prevRd;
        logic       prevStall;
        logic [7:0] stallData;
        prevRd = 1'b0;
        prevStall = 1'b0;
        stallData = 8'h00;
        forever begin
            @(negedge CLK);
            if (!RST) begin
                prevRd = 1'b0;
                prevStall = 1'b0;
            end else begin
                checkOutput("errFlag", 32'(ERR), 32'(expErr));
                checkOutput("rdWhileEmpty", 32'(FIFO_RD & FIFO_EMPTY), 32'd0);
                if (FIFO_RD) begin
                    rdCount++;
                    checkOutput("rdPulseWidth", 32'(prevRd), 32'd0);
                end
                prevRd = FIFO_RD;
                if (FIFO_VALID) validCount++;
                if (prevStall) begin
                    checkOutput("stallValid", 32'(TX_VALID), 32'd1);
                    checkOutput("stallData", 32'(TX_DATA), 32'(stallData));
                end
                if (TX_VALID && TX_READY) begin
                    if (expQ.size() == 0) begin
                        checks++;
                        failures++;
                        $display("[TB] FAIL unexpectedByte: got %0h, required no transfer", TX_DATA);
                    end else begin
                        checkOutput("txByte", 32'(TX_DATA), 32'(expQ.pop_front()));
                    end
                    lastByte = TX_DATA;
                end
                prevStall = TX_VALID && !TX_READY;
                stallData = TX_DATA;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time exceeded, required completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int rd0;
        int vd0;
        int n;

        #2 RST = 1'b0;
        #1;
        checkOutput("resetRd", 32'(FIFO_RD), 32'd0);
        checkOutput("resetData", 32'(TX_DATA), 32'd0);
        checkOutput("resetValid", 32'(TX_VALID), 32'd0);
        checkOutput("resetBusy", 32'(BUSY), 32'd0);
        checkOutput("resetErr", 32'(ERR), 32'd0);
        repeat (2) @(negedge CLK);
        #2 RST = 1'b1;
        repeat (2) @(negedge CLK);

        // Basic packet with an always-ready sink.
        rd0 = rdCount;
        vd0 = validCount;
        applyStimulus(16'h0102); applyStimulus(16'h0304);
        applyStimulus(16'h0506); applyStimulus(16'h0708);
        expectPacket(16'h0102, 16'h0304, 16'h0506, 16'h0708);
        @(negedge CLK);
        checkOutput("hdrLatencyValid", 32'(TX_VALID), 32'd1);
        checkOutput("hdrLatencyData", 32'(TX_DATA), 32'hA5);
        waitDrain("basicDrain", 200);
        checkOutput("basicChecksum", 32'(lastByte), 32'h24);
        checkOutput("basicRdCount", 32'(rdCount - rd0), 32'd4);
        checkOutput("basicValidCount", 32'(validCount - vd0), 32'd4);
        checkOutput("basicBusyIdle", 32'(BUSY), 32'd0);

        // Sink back-pressure while 0x03 is offered.
        stallByte = 8'h03;
        stallLeft = 3;
        applyStimulus(16'h0102); applyStimulus(16'h0304);
        applyStimulus(16'h0506); applyStimulus(16'h0708);
        expectPacket(16'h0102, 16'h0304, 16'h0506, 16'h0708);
        waitDrain("stallDrain", 200);
        checkOutput("stallConsumed", 32'(stallLeft), 32'd0);
        checkOutput("stallChecksum", 32'(lastByte), 32'h24);

        // Fifo runs dry mid-packet; framer waits in REQ.
        applyStimulus(16'h0102); applyStimulus(16'h0304);
        expectPacket(16'h0102, 16'h0304, 16'h0506, 16'h0708);
        repeat (30) @(negedge CLK);
        checkOutput("starveBytesLeft", 32'(expQ.size()), 32'd5);
        checkOutput("starveRd", 32'(FIFO_RD), 32'd0);
        checkOutput("starveBusy", 32'(BUSY), 32'd1);
        checkOutput("starveTxValid", 32'(TX_VALID), 32'd0);
        applyStimulus(16'h0506); applyStimulus(16'h0708);
        waitDrain("starveDrain", 200);
        checkOutput("starveChecksum", 32'(lastByte), 32'h24);

        // Checksum wrap-around.
        for (int i = 0; i < 4; i++) applyStimulus(16'hFFFF);
        expectPacket(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        waitDrain("wrapDrain", 200);
        checkOutput("wrapChecksum", 32'(lastByte), 32'hF8);

        // Missing VALID on the second read aborts the packet; ERR is sticky.
        failAt = readsIssued + 2;
        applyStimulus(16'h1111); applyStimulus(16'h2222);
        expQ.push_back(8'hA5); expQ.push_back(8'h04);
        expQ.push_back(8'h11); expQ.push_back(8'h11);
        waitDrain("abortDrain", 200);
        repeat (5) @(negedge CLK);
        checkOutput("abortStickyErr", 32'(ERR), 32'd1);
        checkOutput("abortIdle", 32'(BUSY), 32'd0);
        applyStimulus(16'h1234); applyStimulus(16'h5678);
        applyStimulus(16'h9ABC); applyStimulus(16'hDEF0);
        expectPacket(16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0);
        waitDrain("afterAbortDrain", 200);
        checkOutput("afterAbortChecksum", 32'(lastByte), 32'h38);
        checkOutput("afterAbortErr", 32'(ERR), 32'd1);

        // Reset while the low payload byte is held by the sink.
        stallByte = 8'h02;
        stallLeft = 1000;
        applyStimulus(16'h0102); applyStimulus(16'h0304);
        applyStimulus(16'h0506); applyStimulus(16'h0708);
        expectPacket(16'h0102, 16'h0304, 16'h0506, 16'h0708);
        n = 0;
        while (!(TX_VALID && TX_DATA == 8'h02 && !TX_READY) && n < 100) begin
            @(negedge CLK);
            n++;
        end
        checkOutput("reachLowByte", 32'(n < 100), 32'd1);
        #2;
        expErr = 1'b0;
        RST = 1'b0;
        #1;
        checkOutput("midResetRd", 32'(FIFO_RD), 32'd0);
        checkOutput("midResetData", 32'(TX_DATA), 32'd0);
        checkOutput("midResetValid", 32'(TX_VALID), 32'd0);
        checkOutput("midResetBusy", 32'(BUSY), 32'd0);
        checkOutput("midResetErr", 32'(ERR), 32'd0);
        expQ.delete();
        stallLeft = 0;
        applyStimulus(16'h090A);
        expectPacket(16'h0304, 16'h0506, 16'h0708, 16'h090A);
        repeat (2) @(negedge CLK);
        #2 RST = 1'b1;
        waitDrain("postResetDrain", 200);
        checkOutput("postResetChecksum", 32'(lastByte), 32'h34);
        checkOutput("postResetErr", 32'(ERR), 32'd0);

        repeat (3) @(negedge CLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
